riscv_pushpop_sequencer: RTL and testbench

Sits in the ID stage directly upstream of riscv_pushpop_controller. It decodes 16-bit Zc push/pop instructions (cm.push, cm.pop, cm.popret, cm.popretz) and latches their fields. It drives rcount/spimm16/pushpop_ctrl to the controller and holds ID/IF until the controller signals done. It then sequences the optional a0-clear and return-jump tails of popretz/popret.

---
 rtl/riscv_pushpop_sequencer_pkg.sv | 9 +
 rtl/riscv_pushpop_sequencer.sv | 82 ++++++++
 tb/tb_riscv_pushpop_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/riscv_pushpop_sequencer_pkg.sv
// riscv_pushpop_sequencer_pkg: Zc push/pop opcodes, instruction kinds and sequencer states
package riscv_pushpop_sequencer_pkg;
  localparam logic [5:0] OPCODE_CM_PUSHPOP = 6'b101110;
  localparam logic [5:0] OPCODE_CM_POPRET = 6'b101111;
  localparam logic [1:0] PP_PUSH = 2'b00;
  localparam logic [1:0] PP_POP = 2'b10;
  typedef enum logic [1:0] {PP_KIND_PUSH, PP_KIND_POP, PP_KIND_POPRET, PP_KIND_POPRETZ} pushpop_kind_e;
  typedef enum logic [1:0] {S_IDLE, S_SEQ, S_ZERO, S_RET} pp_state_e;
endpackage

// File: rtl/riscv_pushpop_sequencer.sv
// riscv_pushpop_sequencer: decodes cm.push/pop/popret/popretz and sequences the controller and return tails
module riscv_pushpop_sequencer
  import riscv_pushpop_sequencer_pkg::*;
#(
  parameter int RLIST_MIN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_rdata_i,
  input  logic        instr_valid_i,
  input  logic        id_valid_i,
  input  logic        kill_i,
  input  logic        pushpop_done_i,
  output logic        pushpop_ctrl_o,
  output logic [3:0]  rcount_o,
  output logic [4:0]  spimm16_o,
  output logic        is_pop_o,
  output logic        halt_id_o,
  output logic        clear_a0_o,
  output logic        ret_jump_o,
  output logic        illegal_insn_o,
  output logic        busy_o
);
  localparam logic [3:0] RMIN = 4'(RLIST_MIN);
  pp_state_e state;
  pushpop_kind_e kind_q, dec_kind;
  logic [3:0] rcount_q, rlist, dec_rcount;
  logic [1:0] spimm_q, sub;
  logic [5:0] op;
  logic is_pp, legal, start, seq, busy, retire;
  always_comb begin
    op = instr_rdata_i[15:10];
    sub = instr_rdata_i[9:8];
    rlist = instr_rdata_i[7:4];
    dec_rcount = rlist - 4'd3;
    is_pp = instr_rdata_i[1:0] == 2'b10 && (op == OPCODE_CM_PUSHPOP || op == OPCODE_CM_POPRET) &&
            (sub == PP_PUSH || sub == PP_POP);
    dec_kind = op == OPCODE_CM_PUSHPOP ? (sub == PP_PUSH ? PP_KIND_PUSH : PP_KIND_POP)
                                       : (sub == PP_PUSH ? PP_KIND_POPRETZ : PP_KIND_POPRET);
    legal = is_pp && rlist >= RMIN;
    busy = state != S_IDLE;
    seq = state == S_SEQ;
    start = !busy && instr_valid_i && legal;
    retire = seq && pushpop_done_i && id_valid_i && (kind_q == PP_KIND_PUSH || kind_q == PP_KIND_POP);
    // The controller samples the decoded fields in the accept cycle, before they are latched
    pushpop_ctrl_o = !kill_i && (start || seq);
    rcount_o = start ? dec_rcount : busy ? rcount_q : 4'd0;
    spimm16_o = start ? {3'b0, instr_rdata_i[3:2]} : busy ? {3'b0, spimm_q} : 5'd0;
    is_pop_o = start ? dec_kind != PP_KIND_PUSH : busy && kind_q != PP_KIND_PUSH;
    halt_id_o = start || (seq && !retire) || state == S_ZERO;
    clear_a0_o = !kill_i && state == S_ZERO;
    ret_jump_o = !kill_i && state == S_RET;
    illegal_insn_o = !busy && instr_valid_i && is_pp && !legal;
    busy_o = busy;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      kind_q <= PP_KIND_PUSH;
      rcount_q <= 4'd0;
      spimm_q <= 2'd0;
    end else if (kill_i) begin
      state <= S_IDLE;
      kind_q <= PP_KIND_PUSH;
      rcount_q <= 4'd0;
      spimm_q <= 2'd0;
    end else begin
      case (state)
        S_IDLE: if (start && id_valid_i) begin
          state <= S_SEQ;
          kind_q <= dec_kind;
          rcount_q <= dec_rcount;
          spimm_q <= instr_rdata_i[3:2];
        end
        S_SEQ: if (pushpop_done_i && id_valid_i)
          state <= kind_q == PP_KIND_POPRETZ ? S_ZERO : kind_q == PP_KIND_POPRET ? S_RET : S_IDLE;
        S_ZERO: if (id_valid_i) state <= S_RET;
        default: if (id_valid_i) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_pushpop_sequencer.sv
// tb_riscv_pushpop_sequencer: directed steps with a scoreboard of expected output vectors
module tb_riscv_pushpop_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] instr_rdata_i;
  logic instr_valid_i, id_valid_i, kill_i, pushpop_done_i;
  logic pushpop_ctrl_o, is_pop_o, halt_id_o, clear_a0_o, ret_jump_o, illegal_insn_o, busy_o;
  logic [3:0] rcount_o;
  logic [4:0] spimm16_o;
  logic [15:0] sb[$];
  int n_assert = 0;
  int n_fail = 0;
  localparam logic [15:0] Z = 16'h0000;
  localparam logic [5:0] OP_PP = 6'b101110;
  localparam logic [5:0] OP_PR = 6'b101111;

  riscv_pushpop_sequencer #(.RLIST_MIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_rdata_i(instr_rdata_i), .instr_valid_i(instr_valid_i),
    .id_valid_i(id_valid_i), .kill_i(kill_i), .pushpop_done_i(pushpop_done_i),
    .pushpop_ctrl_o(pushpop_ctrl_o), .rcount_o(rcount_o), .spimm16_o(spimm16_o), .is_pop_o(is_pop_o),
    .halt_id_o(halt_id_o), .clear_a0_o(clear_a0_o), .ret_jump_o(ret_jump_o),
    .illegal_insn_o(illegal_insn_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] enc(input logic [5:0] op, input logic [1:0] sub, input logic [3:0] rl,
                                      input logic [1:0] sp);
    return {op, sub, rl, sp, 2'b10};
  endfunction

  // {ctrl, rcount, spimm16, is_pop, halt, clear_a0, ret_jump, illegal, busy}
  function automatic logic [15:0] ev(input logic ctrl, input logic [3:0] rc, input logic [1:0] sp,
                                     input logic pop, input logic halt, input logic clr, input logic ret,
                                     input logic ill, input logic busy);
    return {ctrl, rc, 3'b000, sp, pop, halt, clr, ret, ill, busy};
  endfunction

  task automatic step(input string tag, input logic [15:0] ins, input logic iv, input logic idv,
                      input logic kl, input logic dn, input logic [15:0] e);
    logic [15:0] obs, exp_v;
    instr_rdata_i = ins;
    instr_valid_i = iv;
    id_valid_i = idv;
    kill_i = kl;
    pushpop_done_i = dn;
    sb.push_back(e);
    @(negedge clk);
    obs = {pushpop_ctrl_o, rcount_o, spimm16_o, is_pop_o, halt_id_o, clear_a0_o, ret_jump_o,
           illegal_insn_o, busy_o};
    exp_v = sb.pop_front();
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] i;
    rst_n = 1'b0;
    instr_rdata_i = '0;
    instr_valid_i = 1'b0;
    id_valid_i = 1'b0;
    kill_i = 1'b0;
    pushpop_done_i = 1'b0;
    step("reset", Z, 0, 0, 0, 0, Z);
    rst_n = 1'b1;
    step("idle_after_reset", Z, 0, 1, 0, 0, Z);
    // cm.push rlist=5 spimm=1, done on third controller cycle
    i = enc(OP_PP, 2'b00, 4'd5, 2'd1);
    step("push_accept", i, 1, 1, 0, 0, ev(1, 4'd2, 2'd1, 0, 1, 0, 0, 0, 0));
    step("push_seq1", i, 1, 1, 0, 0, ev(1, 4'd2, 2'd1, 0, 1, 0, 0, 0, 1));
    step("push_seq2", i, 1, 1, 0, 0, ev(1, 4'd2, 2'd1, 0, 1, 0, 0, 0, 1));
    step("push_done", i, 1, 1, 0, 1, ev(1, 4'd2, 2'd1, 0, 0, 0, 0, 0, 1));
    step("push_idle", Z, 0, 1, 0, 0, Z);
    // cm.popretz rlist=4 (smallest legal) spimm=0
    i = enc(OP_PR, 2'b00, 4'd4, 2'd0);
    step("popretz_accept", i, 1, 1, 0, 0, ev(1, 4'd1, 2'd0, 1, 1, 0, 0, 0, 0));
    step("popretz_done", i, 1, 1, 0, 1, ev(1, 4'd1, 2'd0, 1, 1, 0, 0, 0, 1));
    step("popretz_zero", Z, 0, 1, 0, 1, ev(0, 4'd1, 2'd0, 1, 1, 1, 0, 0, 1));
    step("popretz_ret", Z, 0, 1, 0, 0, ev(0, 4'd1, 2'd0, 1, 0, 0, 1, 0, 1));
    step("popretz_idle", Z, 0, 1, 0, 0, Z);
    // cm.popret rlist=6 spimm=2, stalled two cycles in RET
    i = enc(OP_PR, 2'b10, 4'd6, 2'd2);
    step("popret_accept", i, 1, 1, 0, 0, ev(1, 4'd3, 2'd2, 1, 1, 0, 0, 0, 0));
    step("popret_done", i, 1, 1, 0, 1, ev(1, 4'd3, 2'd2, 1, 1, 0, 0, 0, 1));
    step("popret_ret_stall1", Z, 0, 0, 0, 0, ev(0, 4'd3, 2'd2, 1, 0, 0, 1, 0, 1));
    step("popret_ret_stall2", Z, 0, 0, 0, 0, ev(0, 4'd3, 2'd2, 1, 0, 0, 1, 0, 1));
    step("popret_ret_go", Z, 0, 1, 0, 0, ev(0, 4'd3, 2'd2, 1, 0, 0, 1, 0, 1));
    step("popret_idle", Z, 0, 1, 0, 0, Z);
    // reserved rlist on cm.pop
    i = enc(OP_PP, 2'b10, 4'd3, 2'd1);
    step("illegal_rlist3", i, 1, 1, 0, 0, ev(0, 4'd0, 2'd0, 0, 0, 0, 0, 1, 0));
    step("illegal_stays_idle", Z, 0, 1, 0, 0, Z);
    // kill during SEQ of cm.popret, coinciding with done
    i = enc(OP_PR, 2'b10, 4'd7, 2'd3);
    step("kill_accept", i, 1, 1, 0, 0, ev(1, 4'd4, 2'd3, 1, 1, 0, 0, 0, 0));
    step("kill_seq", i, 1, 1, 0, 0, ev(1, 4'd4, 2'd3, 1, 1, 0, 0, 0, 1));
    step("kill_cycle", i, 1, 1, 1, 1, ev(0, 4'd4, 2'd3, 1, 1, 0, 0, 0, 1));
    step("kill_idle", Z, 0, 1, 0, 0, Z);
    step("kill_idle2", Z, 0, 1, 0, 1, Z);
    // rlist=15 with ID stalled in IDLE: re-presented until accepted
    i = enc(OP_PP, 2'b00, 4'd15, 2'd3);
    step("r15_stall1", i, 1, 0, 0, 0, ev(1, 4'd12, 2'd3, 0, 1, 0, 0, 0, 0));
    step("r15_stall2", i, 1, 0, 0, 0, ev(1, 4'd12, 2'd3, 0, 1, 0, 0, 0, 0));
    step("r15_accept", i, 1, 1, 0, 0, ev(1, 4'd12, 2'd3, 0, 1, 0, 0, 0, 0));
    step("r15_done", i, 1, 1, 0, 1, ev(1, 4'd12, 2'd3, 0, 0, 0, 0, 0, 1));
    step("r15_idle", Z, 0, 1, 0, 0, Z);
    // non-pushpop encodings and a stray done in IDLE
    step("c_addi", 16'h0505, 1, 1, 0, 1, Z);
    step("c_mv", 16'h852e, 1, 1, 0, 1, Z);
    step("pp_bad_subop", enc(OP_PP, 2'b01, 4'd5, 2'd0), 1, 1, 0, 0, Z);
    step("pp_bad_quadrant", {OP_PP, 2'b00, 4'd5, 2'd0, 2'b01}, 1, 1, 0, 0, Z);
    step("pp_not_valid", enc(OP_PP, 2'b00, 4'd5, 2'd0), 0, 1, 0, 0, Z);
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
